// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: instruction field positions,
// FSM state encoding and one-hot store-data select codes.
package mem_stage_pkg;

    localparam int MEM_EN_BIT = 23;
    localparam int MEM_WR_BIT = 22;
    localparam int WIDE_BIT   = 21;

    localparam int SEL_W = 5;
    localparam logic [SEL_W-1:0] SEL_ST_DATA = 5'b00001;
    localparam logic [SEL_W-1:0] SEL_WB_TOP  = 5'b00010;
    localparam logic [SEL_W-1:0] SEL_WB_BOT  = 5'b00100;
    localparam logic [SEL_W-1:0] SEL_IMM     = 5'b01000;
    localparam logic [SEL_W-1:0] SEL_ZERO    = 5'b10000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2
    } state_t;

endpackage

// File: rtl/memory_stage_store_mux.sv
// One byte lane of store-data resolution: 5:1 one-hot select between register
// data, forwarded MEM/WB bytes, the immediate and zero.
module store_data_mux
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [DATA_W-1:0] wb_top_i,
    input  logic [DATA_W-1:0] wb_bot_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] data_o
);

    // Any select that is not exactly one-hot resolves to zero.
    always_comb begin
        data_o = '0;
        case (sel_i)
            SEL_ST_DATA: data_o = st_data_i;
            SEL_WB_TOP:  data_o = wb_top_i;
            SEL_WB_BOT:  data_o = wb_bot_i;
            SEL_IMM:     data_o = imm_i;
            SEL_ZERO:    data_o = '0;
            default:     data_o = '0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: byte / 16-bit data-memory access over a req/ready
// handshake, store-data forwarding, front-end stall and the MEM/WB register.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              ex_mem_valid,
    input  logic [31:0]       ex_mem_instruction,
    input  logic [DATA_W-1:0] ex_mem_data_top,
    input  logic [DATA_W-1:0] ex_mem_data_bot,
    input  logic [DATA_W-1:0] st_data_top,
    input  logic [DATA_W-1:0] st_data_bot,
    input  logic [SEL_W-1:0]  mem_str_data_sel_top,
    input  logic [SEL_W-1:0]  mem_str_data_sel_bot,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              mem_wb_valid,
    output logic [31:0]       mem_wb_instruction,
    output logic [DATA_W-1:0] mem_wb_data_top,
    output logic [DATA_W-1:0] mem_wb_data_bot
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wtop_q, wtop_d, wbot_q, wbot_d, rlo_q, rlo_d;
    logic [31:0]         instr_q, instr_d;
    logic                wb_valid_q, wb_valid_d;
    logic [31:0]         wb_instr_q, wb_instr_d;
    logic [DATA_W-1:0]   wb_top_q, wb_top_d, wb_bot_q, wb_bot_d;
    logic [DATA_W-1:0]   mux_top, mux_bot;
    logic                issue, is_mem, acc_we, acc_wide;

    store_data_mux #(.DATA_W(DATA_W)) u_mux_top (
        .sel_i     (mem_str_data_sel_top),
        .st_data_i (st_data_top),
        .wb_top_i  (wb_top_q),
        .wb_bot_i  (wb_bot_q),
        .imm_i     (ex_mem_instruction[DATA_W-1:0]),
        .data_o    (mux_top)
    );

    store_data_mux #(.DATA_W(DATA_W)) u_mux_bot (
        .sel_i     (mem_str_data_sel_bot),
        .st_data_i (st_data_bot),
        .wb_top_i  (wb_top_q),
        .wb_bot_i  (wb_bot_q),
        .imm_i     (ex_mem_instruction[DATA_W-1:0]),
        .data_o    (mux_bot)
    );

    assign issue    = ex_mem_valid & ~flush;
    assign is_mem   = ex_mem_instruction[MEM_EN_BIT];
    assign acc_we   = instr_q[MEM_WR_BIT];
    assign acc_wide = instr_q[WIDE_BIT];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wtop_d     = wtop_q;
        wbot_d     = wbot_q;
        rlo_d      = rlo_q;
        instr_d    = instr_q;
        wb_valid_d = 1'b0;
        wb_instr_d = wb_instr_q;
        wb_top_d   = wb_top_q;
        wb_bot_d   = wb_bot_q;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue && !is_mem) begin
                    wb_valid_d = 1'b1;
                    wb_instr_d = ex_mem_instruction;
                    wb_top_d   = ex_mem_data_top;
                    wb_bot_d   = ex_mem_data_bot;
                end else if (issue && is_mem) begin
                    stall   = 1'b1;
                    addr_d  = {ex_mem_data_top, ex_mem_data_bot};
                    wtop_d  = mux_top;
                    wbot_d  = mux_bot;
                    instr_d = ex_mem_instruction;
                    state_d = ACC_LO;
                end
            end
            ACC_LO: begin
                dmem_req   = 1'b1;
                dmem_we    = acc_we;
                dmem_addr  = addr_q;
                dmem_wdata = wbot_q;
                stall      = ~(dmem_ready & ~acc_wide);
                if (dmem_ready) begin
                    rlo_d = dmem_rdata;
                    if (acc_wide) begin
                        state_d = ACC_HI;
                    end else begin
                        state_d    = IDLE;
                        wb_valid_d = 1'b1;
                        wb_instr_d = instr_q;
                        wb_top_d   = acc_we ? addr_q[2*DATA_W-1:DATA_W] : '0;
                        wb_bot_d   = acc_we ? addr_q[DATA_W-1:0] : dmem_rdata;
                    end
                end
            end
            ACC_HI: begin
                // Address increment wraps modulo 2^ADDR_W.
                dmem_req   = 1'b1;
                dmem_we    = acc_we;
                dmem_addr  = addr_q + ADDR_W'(1);
                dmem_wdata = wtop_q;
                stall      = ~dmem_ready;
                if (dmem_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_instr_d = instr_q;
                    wb_top_d   = acc_we ? addr_q[2*DATA_W-1:DATA_W] : dmem_rdata;
                    wb_bot_d   = acc_we ? addr_q[DATA_W-1:0] : rlo_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wtop_q     <= '0;
            wbot_q     <= '0;
            rlo_q      <= '0;
            instr_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_instr_q <= '0;
            wb_top_q   <= '0;
            wb_bot_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wtop_q     <= wtop_d;
            wbot_q     <= wbot_d;
            rlo_q      <= rlo_d;
            instr_q    <= instr_d;
            wb_valid_q <= wb_valid_d;
            wb_instr_q <= wb_instr_d;
            wb_top_q   <= wb_top_d;
            wb_bot_q   <= wb_bot_d;
        end
    end

    assign mem_wb_valid       = wb_valid_q;
    assign mem_wb_instruction = wb_instr_q;
    assign mem_wb_data_top    = wb_top_q;
    assign mem_wb_data_bot    = wb_bot_q;

endmodule
